// File: rtl/dll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dll_lock_ctrl
// Description : DLL lock controller. It filters phase-detector votes into
//               single-tap steps and tracks acquire/track lock status.
// Revision    : 1.0 - initial release
// ============================================================================
module dll_lock_ctrl #(
    parameter int CODE_W  = 6,
    parameter int FILT_TH = 4,
    parameter int REV_N   = 4,
    parameter int LOSS_N  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              pd_early,
    input  logic              pd_late,
    output logic [CODE_W-1:0] delay_code,
    output logic              locked,
    output logic              sat_hi,
    output logic              sat_lo
);

    localparam int ACC_W   = 4;
    localparam int CNT_MAX = (REV_N > LOSS_N) ? REV_N : LOSS_N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ACQUIRE = 2'd1;
    localparam logic [1:0] c_TRACK   = 2'd2;

    localparam logic [CODE_W-1:0]       c_CODE_MAX = '1;
    localparam logic [CODE_W-1:0]       c_CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] c_ONE      = 1;
    localparam logic signed [ACC_W-1:0] c_TH_TRACK = ACC_W'(FILT_TH);
    localparam logic [CNT_W-1:0]        c_REV_N    = CNT_W'(REV_N);
    localparam logic [CNT_W-1:0]        c_LOSS_N   = CNT_W'(LOSS_N);

    logic [1:0]              r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [CODE_W-1:0]       r_code, w_code_nxt;
    logic [CNT_W-1:0]        r_rev_cnt, w_rev_cnt_nxt;
    logic [CNT_W-1:0]        r_run_cnt, w_run_cnt_nxt;
    logic                    r_has_prev, w_has_prev_nxt;
    logic                    r_last_up, w_last_up_nxt;
    logic                    r_locked, w_locked_nxt;
    logic                    r_sat_hi, r_sat_lo;

    logic                    w_up, w_dn, w_active, w_step;
    logic signed [ACC_W-1:0] w_th, w_acc_sum;
    logic                    w_reversal, w_lock_evt, w_loss_evt;
    logic [CNT_W-1:0]        w_rev_inc, w_run_step;

    // Step decision: the filter fires when the accumulator would hit +/-TH.
    assign w_up       = pd_early & ~pd_late;
    assign w_dn       = pd_late & ~pd_early;
    assign w_active   = ena && (r_state != c_IDLE);
    assign w_th       = (r_state == c_TRACK) ? c_TH_TRACK : c_ONE;
    assign w_acc_sum  = w_up ? (r_acc + c_ONE) : (r_acc - c_ONE);
    assign w_step     = w_active && (w_up || w_dn) &&
                        ((w_acc_sum == w_th) || (w_acc_sum == -w_th));
    assign w_reversal = w_step && r_has_prev && (r_last_up != w_up);
    assign w_rev_inc  = r_rev_cnt + 1'b1;
    assign w_run_step = ((r_run_cnt == '0) || (r_last_up != w_up)) ? CNT_W'(1)
                                                                   : r_run_cnt + 1'b1;
    assign w_lock_evt = (r_state == c_ACQUIRE) && w_reversal && (w_rev_inc == c_REV_N);
    assign w_loss_evt = (r_state == c_TRACK) && w_step && (w_run_step == c_LOSS_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!ena) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:    w_state_nxt = c_ACQUIRE;
                c_ACQUIRE: if (w_lock_evt) w_state_nxt = c_TRACK;
                c_TRACK:   if (w_loss_evt) w_state_nxt = c_ACQUIRE;
                default:   w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_acc_nxt      = r_acc;
        w_code_nxt     = r_code;
        w_rev_cnt_nxt  = r_rev_cnt;
        w_run_cnt_nxt  = r_run_cnt;
        w_has_prev_nxt = r_has_prev;
        w_last_up_nxt  = r_last_up;
        w_locked_nxt   = r_locked;
        if (!ena) begin
            w_acc_nxt      = '0;
            w_rev_cnt_nxt  = '0;
            w_run_cnt_nxt  = '0;
            w_has_prev_nxt = 1'b0;
            w_locked_nxt   = 1'b0;
        end else if (w_active && (w_up || w_dn)) begin
            w_acc_nxt = w_step ? '0 : w_acc_sum;
            if (w_step) begin
                // A saturated request still counts as a step in its direction.
                if (w_up && (r_code != c_CODE_MAX)) w_code_nxt = r_code + 1'b1;
                if (w_dn && (r_code != '0))         w_code_nxt = r_code - 1'b1;
                w_has_prev_nxt = 1'b1;
                w_last_up_nxt  = w_up;
                if (r_state == c_ACQUIRE) begin
                    if (w_reversal) w_rev_cnt_nxt = w_rev_inc;
                    if (w_lock_evt) begin
                        w_rev_cnt_nxt = '0;
                        w_run_cnt_nxt = '0;
                        w_locked_nxt  = 1'b1;
                    end
                end else begin
                    w_run_cnt_nxt = w_run_step;
                    if (w_loss_evt) begin
                        w_rev_cnt_nxt = '0;
                        w_run_cnt_nxt = '0;
                        w_locked_nxt  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_code     <= c_CODE_MID;
            r_rev_cnt  <= '0;
            r_run_cnt  <= '0;
            r_has_prev <= 1'b0;
            r_last_up  <= 1'b0;
            r_locked   <= 1'b0;
            r_sat_hi   <= 1'b0;
            r_sat_lo   <= 1'b0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_code     <= w_code_nxt;
            r_rev_cnt  <= w_rev_cnt_nxt;
            r_run_cnt  <= w_run_cnt_nxt;
            r_has_prev <= w_has_prev_nxt;
            r_last_up  <= w_last_up_nxt;
            r_locked   <= w_locked_nxt;
            r_sat_hi   <= (w_code_nxt == c_CODE_MAX);
            r_sat_lo   <= (w_code_nxt == '0);
        end
    end

    assign delay_code = r_code;
    assign locked     = r_locked;
    assign sat_hi     = r_sat_hi;
    assign sat_lo     = r_sat_lo;

endmodule
`default_nettype wire
